// File: rtl/adc_axil_pkg.sv
// Purpose: shared types, response codes and address decode helper for the ADC AXI-Lite write register file.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package adc_axil_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register index of a byte address: keep only the decoded low bits, drop the byte offset.
    function automatic logic [31:0] axil_idx(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] mask;
        mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
        return (addr & mask) >> 2;
    endfunction

endpackage

// File: rtl/adc_axil_wr_reg.sv
// Purpose: one 32-bit register with byte-strobe merge, reset value, self-clearing pulse bits and write strobe.
// Latency: wr_en on edge n -> q and stb updated on edge n; pulse bits clear on the following edge.
// Backpressure: none; a write is taken whenever wr_en is high.
//
// Ports: ACLK/ARESETN clock and async active-low reset; wr_en/wr_data/wr_strb commit request;
//        q current value; stb one-cycle strobe marking the first cycle a new value is visible.
module adc_axil_wr_reg
    import adc_axil_pkg::*;
#(
    parameter logic [31:0] RESET_VAL  = 32'h0,
    parameter logic [31:0] PULSE_MASK = 32'h0
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic [31:0] q,
    output logic        stb
);

    logic [31:0] merged;

    always_comb begin
        merged = q;
        for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
                merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Pulse bits never come out of reset set; they are high only in the cycle after a write of 1.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            q   <= RESET_VAL & ~PULSE_MASK;
            stb <= 1'b0;
        end else begin
            stb <= wr_en;
            if (wr_en) begin
                q <= merged;
            end else begin
                q <= q & ~PULSE_MASK;
            end
        end
    end

endmodule

// File: rtl/adc_axil_wr_regfile.sv
// Purpose: AXI4-Lite write-channel register file of NREG 32-bit registers with byte strobes and SLVERR decode.
// Latency: AW+W both accepted on edge t -> regs/wr_stb/BVALID on edge t+1; 3 cycles minimum per write.
// Backpressure: AWREADY/WREADY drop once their beat is held and stay low until the B handshake completes.
//
// Ports: ACLK/ARESETN clock and async active-low reset; AW*, W*, B* AXI4-Lite write channels;
//        regs flat register contents (reg i at [32i+31:32i]); wr_stb per-register commit strobe.
module adc_axil_wr_regfile
    import adc_axil_pkg::*;
#(
    parameter int                  NREG       = 8,
    parameter int                  ADDR_W     = 8,
    parameter logic [NREG-1:0]     WR_MASK    = '1,
    parameter logic [NREG*32-1:0]  RESET_VAL  = '0,
    parameter logic [31:0]         PULSE_MASK = 32'h1
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [31:0]          AWADDR,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [31:0]          WDATA,
    input  logic [3:0]           WSTRB,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic [1:0]           BRESP,
    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [NREG*32-1:0]   regs,
    output logic [NREG-1:0]      wr_stb
);

    wr_state_t       state;
    logic            aw_held;
    logic            w_held;
    logic [31:0]     aw_addr_q;
    logic [31:0]     w_data_q;
    logic [3:0]      w_strb_q;

    logic            aw_hs;
    logic            w_hs;
    logic [31:0]     idx;
    logic [NREG-1:0] hit;
    logic            addr_ok;
    logic            wr_ok;
    logic [NREG-1:0] wr_en;

    // READY is only ever high in IDLE, so a handshake implies IDLE.
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    // Decode runs off the captured address; it only matters during the WRITE cycle.
    // hit is one-hot for in-range indices and all-zero otherwise, which also covers idx >= NREG.
    always_comb begin
        idx = axil_idx(aw_addr_q, ADDR_W);
        for (int i = 0; i < NREG; i++) begin
            hit[i] = (idx == 32'(i));
        end
        addr_ok = (aw_addr_q[1:0] == 2'b00) && ((aw_addr_q >> ADDR_W) == 32'd0);
        wr_ok   = addr_ok && (|(hit & WR_MASK));
        wr_en   = ((state == WRITE) && wr_ok) ? hit : '0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= 32'h0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            AWREADY   <= 1'b1;
            WREADY    <= 1'b1;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= AWADDR;
                        AWREADY   <= 1'b0;
                    end
                    if (w_hs) begin
                        w_held   <= 1'b1;
                        w_data_q <= WDATA;
                        w_strb_q <= WSTRB;
                        WREADY   <= 1'b0;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        state   <= WRITE;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b0;
                    end
                end
                WRITE: begin
                    BVALID <= 1'b1;
                    BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    state  <= RESP;
                end
                RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= RESP_OKAY;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Only register 0 carries self-clearing pulse bits.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        adc_axil_wr_reg #(
            .RESET_VAL  (RESET_VAL[32*i +: 32]),
            .PULSE_MASK ((i == 0) ? PULSE_MASK : 32'h0)
        ) u_reg (
            .ACLK    (ACLK),
            .ARESETN (ARESETN),
            .wr_en   (wr_en[i]),
            .wr_data (w_data_q),
            .wr_strb (w_strb_q),
            .q       (regs[32*i +: 32]),
            .stb     (wr_stb[i])
        );
    end

endmodule

// File: tb/tb_adc_axil_wr_regfile.sv
module tb_adc_axil_wr_regfile;

    localparam int                 NREG       = 8;
    localparam int                 ADDR_W     = 8;
    localparam logic [NREG-1:0]    WR_MASK    = 8'b0111_1111;
    localparam logic [NREG*32-1:0] RESET_VAL  = {32'hDEADBEEF, 32'h0, 32'h0, 32'h0,
                                                 32'h0, 32'hAABBCCDD, 32'hAABBCCDD, 32'h00000001};
    localparam logic [31:0]        PULSE_MASK = 32'h1;
    // Reset view of regs: register 0 bit 0 is a pulse bit and therefore comes up 0.
    localparam logic [NREG*32-1:0] RESET_SEEN = {32'hDEADBEEF, 32'h0, 32'h0, 32'h0,
                                                 32'h0, 32'hAABBCCDD, 32'hAABBCCDD, 32'h00000000};

    logic                ACLK;
    logic                ARESETN;
    logic [31:0]         AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [31:0]         WDATA;
    logic [3:0]          WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [NREG*32-1:0]  regs;
    logic [NREG-1:0]     wr_stb;

    int errors = 0;
    int checks = 0;
    logic [NREG*32-1:0] exp_regs;

    adc_axil_wr_regfile #(
        .NREG       (NREG),
        .ADDR_W     (ADDR_W),
        .WR_MASK    (WR_MASK),
        .RESET_VAL  (RESET_VAL),
        .PULSE_MASK (PULSE_MASK)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .regs    (regs),
        .wr_stb  (wr_stb)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. lead>0: W leads AW by lead cycles; lead<0: AW leads W; 0: together.
    // stall: cycles BREADY is held low once BVALID is up. exp_idx<0 means no register is written.
    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int lead, input int stall,
                      input logic [1:0] exp_resp, input int exp_idx, input logic [31:0] exp_val);
        logic [NREG-1:0] exp_stb;
        int gap;
        exp_stb = '0;
        if (exp_idx >= 0) exp_stb[exp_idx] = 1'b1;
        gap = (lead < 0) ? -lead : lead;
        BREADY = (stall == 0);
        chk({tag, ".awready_idle"}, AWREADY, 1);
        chk({tag, ".wready_idle"}, WREADY, 1);
        if (lead > 0) begin
            WDATA = data; WSTRB = strb; WVALID = 1'b1;
        end else if (lead < 0) begin
            AWADDR = addr; AWVALID = 1'b1;
        end
        if (lead != 0) begin
            @(negedge ACLK);
            AWVALID = 1'b0; WVALID = 1'b0;
            for (int k = 0; k < gap; k++) begin
                chk({tag, ".held_ready"}, (lead > 0) ? WREADY : AWREADY, 0);
                chk({tag, ".other_ready"}, (lead > 0) ? AWREADY : WREADY, 1);
                chk({tag, ".bvalid_wait"}, BVALID, 0);
                if (k < gap - 1) @(negedge ACLK);
            end
        end
        if (lead >= 0) begin AWADDR = addr; AWVALID = 1'b1; end
        if (lead <= 0) begin WDATA = data; WSTRB = strb; WVALID = 1'b1; end
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk({tag, ".awready_write"}, AWREADY, 0);
        chk({tag, ".wready_write"}, WREADY, 0);
        chk({tag, ".bvalid_write"}, BVALID, 0);
        chk({tag, ".stb_write"}, wr_stb, 0);
        @(negedge ACLK);
        if (exp_idx >= 0) exp_regs[32*exp_idx +: 32] = exp_val;
        chk({tag, ".bvalid"}, BVALID, 1);
        chk({tag, ".bresp"}, BRESP, exp_resp);
        chk({tag, ".wr_stb"}, wr_stb, exp_stb);
        chk({tag, ".regs"}, regs, exp_regs);
        exp_regs[31:0] = exp_regs[31:0] & ~PULSE_MASK;
        for (int k = 0; k < stall; k++) begin
            @(negedge ACLK);
            chk({tag, ".bvalid_stall"}, BVALID, 1);
            chk({tag, ".bresp_stall"}, BRESP, exp_resp);
            chk({tag, ".stb_stall"}, wr_stb, 0);
            chk({tag, ".regs_stall"}, regs, exp_regs);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        chk({tag, ".bvalid_done"}, BVALID, 0);
        chk({tag, ".awready_done"}, AWREADY, 1);
        chk({tag, ".wready_done"}, WREADY, 1);
        chk({tag, ".stb_done"}, wr_stb, 0);
        chk({tag, ".regs_done"}, regs, exp_regs);
        BREADY = 1'b0;
    endtask

    initial begin
        ARESETN = 1'b0;
        AWADDR = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0;
        exp_regs = RESET_SEEN;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);

        chk("rst.regs", regs, RESET_SEEN);
        chk("rst.awready", AWREADY, 1);
        chk("rst.wready", WREADY, 1);
        chk("rst.bvalid", BVALID, 0);
        chk("rst.bresp", BRESP, 2'b00);
        chk("rst.wr_stb", wr_stb, 0);

        wr("w_first",   32'h08,  32'h11223344, 4'hF,    5,  0, 2'b00, 2, 32'h11223344);
        wr("strobe",    32'h04,  32'h11223344, 4'b0101, 0,  0, 2'b00, 1, 32'hAA22CC44);
        wr("aw_first",  32'h14,  32'hCAFEF00D, 4'hF,   -3,  0, 2'b00, 5, 32'hCAFEF00D);
        wr("oob",       32'h20,  32'h12345678, 4'hF,    0,  0, 2'b10, -1, 32'h0);
        wr("misalign",  32'h06,  32'h12345678, 4'hF,    0,  0, 2'b10, -1, 32'h0);
        wr("readonly",  32'h1C,  32'h12345678, 4'hF,    0,  0, 2'b10, -1, 32'h0);
        wr("high_addr", 32'h104, 32'h12345678, 4'hF,    0,  0, 2'b10, -1, 32'h0);
        wr("strb0",     32'h0C,  32'hFFFFFFFF, 4'h0,    0,  0, 2'b00, 3, 32'h0);
        wr("pulse",     32'h00,  32'h00000003, 4'hF,    0, 10, 2'b00, 0, 32'h00000003);
        wr("pulse2",    32'h00,  32'h00000003, 4'hF,    0,  0, 2'b00, 0, 32'h00000003);

        // Reset while BVALID is stalled in RESP.
        BREADY = 1'b0;
        AWADDR = 32'h0C; AWVALID = 1'b1;
        WDATA = 32'h00000055; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        chk("rstmid.bvalid_pre", BVALID, 1);
        chk("rstmid.reg3_pre", regs[32*3 +: 32], 32'h00000055);
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        chk("rstmid.bvalid", BVALID, 0);
        chk("rstmid.regs", regs, RESET_SEEN);
        chk("rstmid.awready", AWREADY, 1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        exp_regs = RESET_SEEN;
        @(negedge ACLK);
        wr("after_rst", 32'h0C, 32'h0000A5A5, 4'hF, 0, 0, 2'b00, 3, 32'h0000A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adc_axil_wr_regfile.md
# adc_axil_wr_regfile

Parametrised AXI4-Lite write-channel register file for the ADC input IP family. It replaces fixed per-register write decoders with NREG generic 32-bit registers and honours byte strobes. Address and data phases are accepted independently, in either order. Bad writes get an SLVERR response, and the block raises per-register write strobes and self-clearing pulse bits. It sits between the AXI-Lite slave port and the capture/level-start logic, which consumes `regs` and `wr_stb`.

## Interface
- `NREG`, 8: number of 32-bit registers at byte offsets 0, 4, …, 4·(NREG−1); 1..64.
- `ADDR_W`, 8: decoded AWADDR bits; must satisfy 2^ADDR_W ≥ 4·NREG.
- `WR_MASK`, all-ones [NREG-1:0]: bit i=1 means register i is writable; 0 means read-only, and writes to it return SLVERR.
- `RESET_VAL`, 0 [NREG*32-1:0]: reset value of register i in slice [32i+31:32i].
- `PULSE_MASK`, 32'h1 [31:0]: bits of register 0 that self-clear one cycle after being written 1 (e.g. start).
- `ACLK` in 1: clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `AWADDR` in 32, `AWVALID` in 1, `AWREADY` out 1: write address channel.
- `WDATA` in 32, `WSTRB` in 4, `WVALID` in 1, `WREADY` out 1: write data channel.
- `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response channel.
- `regs` out NREG*32: current register contents, flat, register i at [32i+31:32i].
- `wr_stb` out NREG: one-cycle strobe, bit i high for the cycle in which register i first shows a newly committed value.

## Operation
- State machine states: IDLE, WRITE, RESP.
  - IDLE collects the address and data phases.
  - WRITE is a single commit cycle.
  - RESP holds the response.
- Internal holding flags `aw_held` and `w_held`, each with a capture register (address; data plus strobe).
- In IDLE:
  - AWREADY = !aw_held.
  - WREADY = !w_held.
  - A beat is captured on the edge where VALID && READY.
  - Both beats may be captured on the same edge.
  - Either beat may arrive first, with any gap.
- IDLE→WRITE on the edge where both flags would be set (held or captured on that edge).
- AWREADY and WREADY are 0 in WRITE and RESP. No new transaction is accepted until B completes.
- Decode in WRITE: idx = addr[ADDR_W-1:2].
  - The write is OK when all hold: idx < NREG, addr[1:0]==0, addr[31:ADDR_W]==0, WR_MASK[idx]==1.
  - Otherwise the write is an error.
- OK write: for each byte b with WSTRB[b]=1, reg[idx][8b+7:8b] ← WDATA[8b+7:8b]. Unstrobed bytes are kept.
  - WSTRB=0 is still OK and pulses `wr_stb`, but changes no data.
- Error write: no register changes, no `wr_stb`, BRESP = 2'b10 (SLVERR).
- WRITE→RESP unconditionally after one cycle.
- RESP: BVALID=1, BRESP holds the decoded value stable until the handshake. RESP→IDLE on BVALID && BREADY. Flags clear on that edge.
- Pulse bits: any bit of register 0 in PULSE_MASK written 1 reads 1 for exactly one cycle, then clears to 0 by hardware. Non-pulse bits hold.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, flags cleared.
  - AWREADY=1, WREADY=1, BVALID=0, BRESP=00.
  - `regs` = RESET_VAL with PULSE_MASK bits of register 0 forced 0.
  - `wr_stb` = 0.
- Latency, with AW and W both handshaken on edge t:
  - Edge t+1 updates `regs` and asserts `wr_stb`.
  - BVALID is high from cycle t+1 onward, so BVALID and `wr_stb` rise together.
  - Pulse bits are high in cycle t+1 and low from edge t+2.
- With BREADY held 1, the minimum transaction takes 3 cycles, and AWREADY returns 1 the cycle after the B handshake.
- `wr_stb` is exactly 1 cycle wide regardless of BREADY stall. Register values persist across the stall.
- Reset mid-transaction (any state) aborts it: no partial commit, BVALID drops immediately, and registers return to reset values.
- Back-to-back writes to the same pulse bit produce one pulse per write, never a merged level.

## Structure
- Package `adc_axil_pkg` holds:
  - the state enum {IDLE, WRITE, RESP};
  - constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - function `axil_idx` (address → register index).
- One natural sub-module, `adc_axil_wr_reg`: a single 32-bit register with byte-strobe merge, reset value, pulse mask and strobe output.
  - Instantiated NREG times by generate.
  - Only index 0 gets the non-zero pulse mask.
- The top level holds the FSM, capture registers and decode.

## Test plan
- After reset, `regs` equals RESET_VAL, AWREADY=WREADY=1 and BVALID=0.
- Write-data first, with register 2 holding 0xAABBCCDD: W (0x11223344, strobe 0xF) at cycle 0, then AW=0x08 at cycle 5 → register 2 = 0x11223344, `wr_stb`[2] pulses once, BRESP=00.
- Byte strobe, with register 1 holding 0xAABBCCDD: write 0x11223344 with strobe 4'b0101 → register 1 = 0xAA22CC44.
- Error cases → BRESP=10 and no register or `wr_stb` change:
  - AWADDR = 4·NREG;
  - AWADDR=0x06 (misaligned);
  - a register with WR_MASK bit 0.
- Pulse bit: write 0x3 to register 0 with PULSE_MASK=0x1 → bit0 high for exactly one cycle, bit1 stays 1. With BREADY held low for 10 cycles, BVALID stays high and BRESP stays stable.
- Assert ARESETN low while in RESP → BVALID=0 immediately, registers return to RESET_VAL, and the next write completes normally.
